// File: rtl/gstmcu_vid_pkg.sv
// Shared types and default window geometry for the GSTMCU vertical timing path.
package gstmcu_vid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VSYNC   = 3'd1,
    ST_TOP     = 3'd2,
    ST_DISPLAY = 3'd3,
    ST_BOTTOM  = 3'd4
  } vstate_e;

  localparam int unsigned DEF_PAL_TOP     = 63;
  localparam int unsigned DEF_NTSC_TOP    = 34;
  localparam int unsigned DEF_MONO_TOP    = 34;
  localparam int unsigned DEF_COLOR_LINES = 200;
  localparam int unsigned DEF_MONO_LINES  = 400;

endpackage

// File: rtl/vs_edge.sv
// Registers vsync_n and emits single-cycle fall/rise pulses (combinational from the register).
// A fall is only reported once vsync_n has been seen high after reset, so a held-low sync is ignored.
module vs_edge (
  input  logic clk32,
  input  logic resb,
  input  logic vsync_n,
  output logic fall,
  output logic rise
);

  logic vs_q, vs_d;
  logic seen_hi_q, seen_hi_d;

  always_comb begin
    vs_d      = vsync_n;
    seen_hi_d = seen_hi_q | vsync_n;
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      vs_q      <= 1'b1;
      seen_hi_q <= 1'b0;
    end else begin
      vs_q      <= vs_d;
      seen_hi_q <= seen_hi_d;
    end
  end

  assign fall = seen_hi_q & vs_q & ~vsync_n;
  assign rise = ~vs_q & vsync_n;

endmodule

// File: rtl/vtiming_ctrl.sv
// Vertical timing controller: frame-aligned mode apply, line counting and the vde/field sequence.
// Mode bits only change the cycle after a vsync_n falling edge, so a frame never sees a mode switch.
module vtiming_ctrl
  import gstmcu_vid_pkg::*;
#(
  parameter int unsigned PAL_TOP     = DEF_PAL_TOP,
  parameter int unsigned NTSC_TOP    = DEF_NTSC_TOP,
  parameter int unsigned MONO_TOP    = DEF_MONO_TOP,
  parameter int unsigned COLOR_LINES = DEF_COLOR_LINES,
  parameter int unsigned MONO_LINES  = DEF_MONO_LINES
) (
  input  logic       clk32,
  input  logic       resb,
  input  logic       mode_we,
  input  logic       mode_mono,
  input  logic       mode_ntsc,
  input  logic       interlace,
  input  logic       line_tick,
  input  logic       vsync_n,
  output logic       mde1,
  output logic       mde1b,
  output logic       ntsc,
  output logic       vde,
  output logic       vblank,
  output logic       field,
  output logic [8:0] line_cnt,
  output logic       mode_pending,
  output logic       frame_err
);

  localparam logic [8:0] CNT_MAX = 9'h1FF;

  logic fs, vs_rise;

  vs_edge u_vs_edge (
    .clk32   (clk32),
    .resb    (resb),
    .vsync_n (vsync_n),
    .fall    (fs),
    .rise    (vs_rise)
  );

  vstate_e    state_q, state_d;
  logic       shadow_mono_q, shadow_mono_d;
  logic       shadow_ntsc_q, shadow_ntsc_d;
  logic       mde1_q, mde1_d;
  logic       ntsc_q, ntsc_d;
  logic       vde_q, vde_d;
  logic       field_q, field_d;
  logic [8:0] line_cnt_q, line_cnt_d;
  logic       frame_err_q, frame_err_d;

  // Window bounds come from the applied mode; 10 bits so top+lines cannot wrap.
  logic [9:0] top_w, end_w, cnt_p1;

  always_comb begin
    if (mde1_q)      top_w = 10'(MONO_TOP);
    else if (ntsc_q) top_w = 10'(NTSC_TOP);
    else             top_w = 10'(PAL_TOP);
    end_w  = top_w + (mde1_q ? 10'(MONO_LINES) : 10'(COLOR_LINES));
    cnt_p1 = {1'b0, line_cnt_q} + 10'd1;
  end

  always_comb begin
    shadow_mono_d = shadow_mono_q;
    shadow_ntsc_d = shadow_ntsc_q;
    mde1_d        = mde1_q;
    ntsc_d        = ntsc_q;
    field_d       = field_q;
    line_cnt_d    = line_cnt_q;
    state_d       = state_q;

    // The apply reads the pre-write shadow, so a coincident write waits a frame.
    if (mode_we) begin
      shadow_mono_d = mode_mono;
      shadow_ntsc_d = mode_ntsc;
    end

    if (fs) begin
      mde1_d     = shadow_mono_q;
      ntsc_d     = shadow_ntsc_q;
      field_d    = interlace ? ~field_q : 1'b0;
      line_cnt_d = 9'd0;
    end else if (line_tick && (line_cnt_q != CNT_MAX)) begin
      line_cnt_d = line_cnt_q + 9'd1;
    end

    frame_err_d = frame_err_q | (line_cnt_d == CNT_MAX);

    if (fs) begin
      state_d = ST_VSYNC;
    end else begin
      unique case (state_q)
        ST_VSYNC:   if (vs_rise) state_d = ST_TOP;
        ST_TOP:     if (line_tick && (cnt_p1 == top_w)) state_d = ST_DISPLAY;
        ST_DISPLAY: if (line_tick && (cnt_p1 == end_w)) state_d = ST_BOTTOM;
        ST_IDLE, ST_BOTTOM: state_d = state_q;
        default:    state_d = ST_IDLE;
      endcase
    end

    vde_d = (state_d == ST_DISPLAY);
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q       <= ST_IDLE;
      shadow_mono_q <= 1'b0;
      shadow_ntsc_q <= 1'b0;
      mde1_q        <= 1'b0;
      ntsc_q        <= 1'b0;
      vde_q         <= 1'b0;
      field_q       <= 1'b0;
      line_cnt_q    <= 9'd0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_mono_q <= shadow_mono_d;
      shadow_ntsc_q <= shadow_ntsc_d;
      mde1_q        <= mde1_d;
      ntsc_q        <= ntsc_d;
      vde_q         <= vde_d;
      field_q       <= field_d;
      line_cnt_q    <= line_cnt_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign mde1         = mde1_q;
  assign mde1b        = ~mde1_q;
  assign ntsc         = ntsc_q;
  assign vde          = vde_q;
  assign vblank       = ~vde_q;
  assign field        = field_q;
  assign line_cnt     = line_cnt_q;
  assign frame_err    = frame_err_q;
  assign mode_pending = (shadow_mono_q != mde1_q) | (shadow_ntsc_q != ntsc_q);

endmodule
